// File: rtl/tl_pkg.sv
// Shared definitions for the highway/farm-road light controller and its timer:
// controller state encodings, default timing constants and a width helper.
package tl_pkg;

    typedef enum logic [1:0] {
        S_HG = 2'b00,
        S_HY = 2'b01,
        S_FG = 2'b10,
        S_FY = 2'b11
    } tl_state_e;

    localparam int DEF_PRESCALE    = 50;
    localparam int DEF_SHORT_TICKS = 5;
    localparam int DEF_LONG_TICKS  = 25;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_DEB_CYCLES  = 4;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) <= max_val) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/car_debounce.sv
// Farm-road car sensor conditioning: two-flop synchronizer followed by a
// debounce counter; C only follows the synchronized sensor after it has
// disagreed with C for DEB_CYCLES consecutive cycles.
module car_debounce
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic car_raw,
    output logic C
);

    localparam int DW = cnt_width(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          s1_r;
    logic          s2_r;
    logic          c_r;
    logic [DW-1:0] deb_cnt_r;

    // Synchronizer, debounce counter and the debounced car flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r      <= 1'b0;
            s2_r      <= 1'b0;
            c_r       <= 1'b0;
            deb_cnt_r <= {DW{1'b0}};
        end else begin
            s1_r <= car_raw;
            s2_r <= s1_r;
            if (s2_r == c_r) begin
                deb_cnt_r <= {DW{1'b0}};
            end else if (deb_cnt_r == DEB_LAST) begin
                c_r       <= s2_r;
                deb_cnt_r <= {DW{1'b0}};
            end else begin
                deb_cnt_r <= deb_cnt_r + DW'(1);
            end
        end
    end

    assign C = c_r;

endmodule

// File: rtl/traffic_timer.sv
// Interval timer for the light controller: a prescaled tick counter restarted
// by ST, with registered short/long expiry flags, plus the debounced car input.
module traffic_timer
    import tl_pkg::*;
#(
    parameter int PRESCALE    = DEF_PRESCALE,
    parameter int SHORT_TICKS = DEF_SHORT_TICKS,
    parameter int LONG_TICKS  = DEF_LONG_TICKS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ST,
    input  logic             car_raw,
    output logic             TS,
    output logic             TL,
    output logic             C,
    output logic             tick,
    output logic [CNT_W-1:0] elapsed
);

    localparam int PW = cnt_width(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] SHORT_V  = CNT_W'(SHORT_TICKS);
    localparam logic [CNT_W-1:0] LONG_V   = CNT_W'(LONG_TICKS);

    logic [PW-1:0]    presc_r;
    logic [PW-1:0]    presc_nxt_s;
    logic             tick_r;
    logic [CNT_W-1:0] elapsed_r;
    logic [CNT_W-1:0] elapsed_nxt_s;
    logic             ts_r;
    logic             tl_r;

    // Next prescaler and elapsed values; ST wins over a tick in the same cycle.
    always_comb begin
        presc_nxt_s   = presc_r;
        elapsed_nxt_s = elapsed_r;
        if (ST) begin
            presc_nxt_s   = {PW{1'b0}};
            elapsed_nxt_s = {CNT_W{1'b0}};
        end else begin
            if (presc_r == PRE_LAST) begin
                presc_nxt_s = {PW{1'b0}};
            end else begin
                presc_nxt_s = presc_r + PW'(1);
            end
            if (tick_r && (elapsed_r != LONG_V)) begin
                elapsed_nxt_s = elapsed_r + CNT_W'(1);
            end else begin
                elapsed_nxt_s = elapsed_r;
            end
        end
    end

    // Flags are registered from the next elapsed value, so TS/TL change on the
    // same edge as elapsed yet carry no combinational path from ST.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r   <= {PW{1'b0}};
            tick_r    <= 1'b0;
            elapsed_r <= {CNT_W{1'b0}};
            ts_r      <= 1'b0;
            tl_r      <= 1'b0;
        end else begin
            presc_r   <= presc_nxt_s;
            tick_r    <= (presc_nxt_s == PRE_LAST);
            elapsed_r <= elapsed_nxt_s;
            ts_r      <= (elapsed_nxt_s >= SHORT_V);
            tl_r      <= (elapsed_nxt_s >= LONG_V);
        end
    end

    car_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_car_debounce (
        .clk    (clk),
        .reset  (reset),
        .car_raw(car_raw),
        .C      (C)
    );

    assign TS      = ts_r;
    assign TL      = tl_r;
    assign tick    = tick_r;
    assign elapsed = elapsed_r;

endmodule

// File: tb/tb_traffic_timer.sv
// Scoreboard bench for traffic_timer: stimulus pushes expected outputs from a
// behavioural model, a monitor pops and compares after every clock edge.
module tb_traffic_timer;
    import tl_pkg::*;

    localparam int P     = 2;
    localparam int SHORT = 3;
    localparam int LONG  = 6;
    localparam int CW    = 8;
    localparam int DEB   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ST = 1'b0;
    logic          car_raw = 1'b1;
    logic          TS, TL, C, tick;
    logic [CW-1:0] elapsed;

    traffic_timer #(
        .PRESCALE(P), .SHORT_TICKS(SHORT), .LONG_TICKS(LONG),
        .CNT_W(CW), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .ST(ST), .car_raw(car_raw),
        .TS(TS), .TL(TL), .C(C), .tick(tick), .elapsed(elapsed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_no;
        bit tick;
        int elapsed;
        bit ts;
        bit tl;
        bit c;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model state: edge index, edge of last restart, car path history.
    int  edge_no    = 0;
    int  last_start = 0;
    bit  h_s1 = 1'b0, h_s2 = 1'b0, h_c = 1'b0;
    int  diff_run = 0;

    // Closed-loop controller state.
    tl_state_e cs = S_HG;
    int hy_low = 0, hg_len = 0, hy_exits = 0, hg_exits = 0;

    function automatic void chk(string name, int at_edge, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s edge %0d: got %0d expected %0d", name, at_edge, act, exp_v);
        end
    endfunction

    // One clock of stimulus; with ctrl set, ST comes from the bench controller.
    task automatic step(input bit r, input bit st_in, input bit car, input bit ctrl);
        exp_t e;
        bit   st;
        bit   go;
        int   d;
        @(negedge clk);
        st = st_in;
        if (ctrl) begin
            case (cs)
                S_HG:    go = C && TL;
                S_HY:    go = TS;
                S_FG:    go = !C || TL;
                S_FY:    go = TS;
                default: go = 1'b0;
            endcase
            if (cs == S_HY && !TS) hy_low++;
            if (cs == S_HG) hg_len++;
            st = go;
            if (go) begin
                if (cs == S_HY) begin
                    chk("hy_ts_low_cycles", edge_no, hy_low, 6);
                    hy_exits++;
                end
                if (cs == S_HG) begin
                    chk("hg_min_cycles", edge_no, (hg_len >= 12) ? 1 : 0, 1);
                    hg_exits++;
                end
                hy_low = 0;
                hg_len = 0;
                cs = tl_state_e'(cs + 2'd1);
            end
        end
        reset   = r;
        ST      = st;
        car_raw = car;
        edge_no++;
        e.edge_no = edge_no;
        if (r) begin
            last_start = edge_no;
            e.tick = 1'b0;
            h_s1 = 1'b0; h_s2 = 1'b0; h_c = 1'b0; diff_run = 0;
        end else begin
            if (st) last_start = edge_no;
            d = edge_no - last_start;
            e.tick = ((d % P) == P - 1);
            // C flips once s2 has disagreed with it for DEB edges in a row.
            if (h_s2 != h_c) begin
                diff_run++;
                if (diff_run == DEB) begin
                    h_c = h_s2;
                    diff_run = 0;
                end
            end else begin
                diff_run = 0;
            end
            h_s2 = h_s1;
            h_s1 = car;
        end
        d = edge_no - last_start;
        e.elapsed = (d / P > LONG) ? LONG : d / P;
        e.ts = (e.elapsed >= SHORT);
        e.tl = (e.elapsed >= LONG);
        e.c  = h_c;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT against each queued expectation after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tick",    e.edge_no, tick,    e.tick);
                chk("elapsed", e.edge_no, elapsed, e.elapsed);
                chk("TS",      e.edge_no, TS,      e.ts);
                chk("TL",      e.edge_no, TL,      e.tl);
                chk("C",       e.edge_no, C,       e.c);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        bit car_s;
        // Reset held with the car sensor active.
        repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Single ST pulse, run past saturation.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (16) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Restart mid-interval, then run to TL.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (14) step(1'b0, 1'b0, 1'b0, 1'b0);
        // ST on the cycle tick is high, then ST held several cycles.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Car glitch, then a clean press and release.
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Randomized traffic.
        car_s = 1'b0;
        repeat (400) begin
            if ($urandom_range(0, 5) == 0) car_s = ~car_s;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), car_s, 1'b0);
        end
        // Mid-interval reset.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (9) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Closed loop with a bench controller, car waiting throughout.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        cs = S_HG;
        hy_low = 0;
        hg_len = 0;
        repeat (100) step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("hy_exit_count", edge_no, (hy_exits >= 2) ? 1 : 0, 1);
        chk("hg_exit_count", edge_no, (hg_exits >= 2) ? 1 : 0, 1);
        @(posedge clk);
        #2;
        chk("queue_drained", edge_no, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
